// File: rtl/sdram_bridge_pkg.sv
// Shared types and helpers for the level-strobe to toggle-handshake sdram bridge.
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_PEND = 2'd2
  } chan_state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // Pick the addressed byte out of a 16-bit sdram word.
  function automatic logic [7:0] byte_sel(input logic addr0, input logic [15:0] q16);
    return addr0 ? q16[15:8] : q16[7:0];
  endfunction

endpackage

// File: rtl/sdram_req_chan.sv
// One bridge channel: strobe edge detect, one-deep pending slot, toggle
// handshake FSM, read byte extraction and a handshake watchdog.
module sdram_req_chan
  import sdram_bridge_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          oe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          busy,
  output logic          err,
  output logic          sd_req,
  input  logic          sd_ack,
  output logic [AW-2:0] sd_a,
  output logic [1:0]    sd_ds,
  output logic          sd_we,
  output logic [15:0]   sd_d,
  input  logic [15:0]   sd_q
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  chan_state_t state, nstate;

  logic          rd, wr, rd_old, wr_old;
  logic [AW-1:0] a_old;
  logic          trig, done, fire, lost;
  logic          issue, use_pend, store_pend;
  logic [AW-1:0] pend_a, src_a;
  logic          pend_we, src_we;
  logic [7:0]    pend_din, src_din;
  logic          cur_lsb;
  logic [CW-1:0] cnt;

  assign rd   = cs & oe;
  assign wr   = cs & we;
  assign trig = (rd & ~rd_old) | (wr & ~wr_old) | (rd & (addr != a_old));
  assign done = (state != IDLE) && (sd_ack == sd_req);
  assign fire = (TIMEOUT != 0) && (state != IDLE) && !done && (cnt == TMAX);
  assign busy = (state != IDLE);

  assign src_a   = use_pend ? pend_a   : addr;
  assign src_we  = use_pend ? pend_we  : we;
  assign src_din = use_pend ? pend_din : din;

  always_comb begin
    nstate     = state;
    issue      = 1'b0;
    use_pend   = 1'b0;
    store_pend = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          issue  = 1'b1;
          nstate = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          if (trig) issue = 1'b1;
          else      nstate = IDLE;
        end else if (trig) begin
          store_pend = 1'b1;
          nstate     = WAIT_PEND;
        end else if (fire) begin
          nstate = IDLE;
        end
      end
      WAIT_PEND: begin
        // A watchdog resync stays here; the forced sd_req==sd_ack reads as done next cycle.
        if (done) begin
          issue      = 1'b1;
          use_pend   = 1'b1;
          store_pend = trig;
          nstate     = trig ? WAIT_PEND : WAIT;
        end else if (trig) begin
          store_pend = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sd_req   <= sd_ack;
      rd_old   <= rd;
      wr_old   <= wr;
      a_old    <= addr;
      pend_a   <= '0;
      pend_we  <= 1'b0;
      pend_din <= '0;
      sd_a     <= '0;
      sd_ds    <= '0;
      sd_we    <= 1'b0;
      sd_d     <= '0;
      cur_lsb  <= 1'b0;
      dout     <= '0;
      err      <= 1'b0;
      lost     <= 1'b0;
      cnt      <= '0;
    end else begin
      state  <= nstate;
      rd_old <= rd;
      wr_old <= wr;
      a_old  <= addr;
      if (store_pend) begin
        pend_a   <= addr;
        pend_we  <= we;
        pend_din <= din;
      end
      // An abandoned (resynced) read never updates dout.
      if (done && !sd_we && !lost) dout <= byte_sel(cur_lsb, sd_q);
      if (issue) begin
        sd_req  <= ~sd_req;
        sd_a    <= src_a[AW-1:1];
        cur_lsb <= src_a[0];
        sd_we   <= src_we;
        sd_ds   <= src_we ? (src_a[0] ? DS_HI : DS_LO) : DS_WORD;
        sd_d    <= {src_din, src_din};
      end else if (fire) begin
        sd_req <= sd_ack;
      end
      if (fire) err <= 1'b1;
      if (fire)      lost <= (nstate == WAIT_PEND);
      else if (done) lost <= 1'b0;
      if (state == IDLE || done || fire) cnt <= '0;
      else if (cnt != TMAX)              cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sdram_req_bridge.sv
// NPORTS independent cs/oe/we client channels bridged onto sdram toggle req/ack ports.
module sdram_req_bridge #(
  parameter int NPORTS  = 2,
  parameter int AW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      cs,
  input  logic [NPORTS-1:0]      oe,
  input  logic [NPORTS-1:0]      we,
  input  logic [NPORTS*AW-1:0]   addr,
  input  logic [NPORTS*8-1:0]    din,
  output logic [NPORTS*8-1:0]    dout,
  output logic [NPORTS-1:0]      busy,
  output logic [NPORTS-1:0]      err,
  output logic [NPORTS-1:0]      sd_req,
  input  logic [NPORTS-1:0]      sd_ack,
  output logic [NPORTS*(AW-1)-1:0] sd_a,
  output logic [NPORTS*2-1:0]    sd_ds,
  output logic [NPORTS-1:0]      sd_we,
  output logic [NPORTS*16-1:0]   sd_d,
  input  logic [NPORTS*16-1:0]   sd_q
);

  for (genvar i = 0; i < NPORTS; i++) begin : g_chan
    sdram_req_chan #(
      .AW      (AW),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .cs     (cs[i]),
      .oe     (oe[i]),
      .we     (we[i]),
      .addr   (addr[i*AW +: AW]),
      .din    (din[i*8 +: 8]),
      .dout   (dout[i*8 +: 8]),
      .busy   (busy[i]),
      .err    (err[i]),
      .sd_req (sd_req[i]),
      .sd_ack (sd_ack[i]),
      .sd_a   (sd_a[i*(AW-1) +: (AW-1)]),
      .sd_ds  (sd_ds[i*2 +: 2]),
      .sd_we  (sd_we[i]),
      .sd_d   (sd_d[i*16 +: 16]),
      .sd_q   (sd_q[i*16 +: 16])
    );
  end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Bench for sdram_req_bridge: transaction-level reference model, per-cycle compare,
// sdram ack responder with per-channel delay, and directed scenarios.
module tb_sdram_req_bridge;
  localparam int NP = 2;
  localparam int AW = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0]      cs = '0, oe = '0, we = '0;
  logic [NP*AW-1:0]   addr = '0;
  logic [NP*8-1:0]    din = '0;
  logic [NP*8-1:0]    dout;
  logic [NP-1:0]      busy, err, sd_req, sd_we;
  logic [NP-1:0]      sd_ack = '0;
  logic [NP*(AW-1)-1:0] sd_a;
  logic [NP*2-1:0]    sd_ds;
  logic [NP*16-1:0]   sd_d;
  logic [NP*16-1:0]   sd_q = '0;

  always #5 clk = ~clk;

  sdram_req_bridge #(.NPORTS(NP), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cs(cs), .oe(oe), .we(we), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .err(err), .sd_req(sd_req), .sd_ack(sd_ack),
    .sd_a(sd_a), .sd_ds(sd_ds), .sd_we(sd_we), .sd_d(sd_d), .sd_q(sd_q)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // sdram responder: acks after ack_dly clocks of mismatch (0 = never).
  int          ack_dly[NP];
  logic [15:0] qval[NP];
  int          rage[NP];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NP; i++) begin
      if (reset || sd_req[i] == sd_ack[i]) rage[i] = 0;
      else begin
        rage[i]++;
        if (ack_dly[i] > 0 && rage[i] >= ack_dly[i]) begin
          sd_ack[i] = sd_req[i];
          sd_q[i*16 +: 16] = qval[i];
          rage[i] = 0;
        end
      end
    end
  end

  // Reference model: one outstanding request plus one pending slot per channel.
  bit          m_req[NP], m_out[NP], m_hp[NP], m_err[NP], m_we[NP], m_lsb[NP];
  logic [14:0] m_a[NP];
  logic [1:0]  m_ds[NP];
  logic [15:0] m_d[NP];
  logic [7:0]  m_dout[NP];
  logic [15:0] pa[NP];
  bit          pw[NP];
  logic [7:0]  pd[NP];
  bit          p_rd[NP], p_wr[NP];
  logic [15:0] p_ad[NP];
  int          age[NP];
  logic [15:0] na, la, q;
  logic [7:0]  ld;
  bit          nrd, nwr, st, cmp, tmo, lw, launched;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      na  = addr[i*AW +: AW];
      nrd = cs[i] & oe[i];
      nwr = cs[i] & we[i];
      if (reset) begin
        m_req[i] = sd_ack[i]; m_out[i] = 0; m_hp[i] = 0; m_err[i] = 0;
        m_dout[i] = '0; m_a[i] = '0; m_ds[i] = '0; m_we[i] = 0; m_d[i] = '0;
        m_lsb[i] = 0; age[i] = 0;
      end else begin
        st  = (nrd && !p_rd[i]) || (nwr && !p_wr[i]) || (nrd && na != p_ad[i]);
        cmp = m_out[i] && (sd_ack[i] == m_req[i]);
        tmo = m_out[i] && !cmp && (TO > 0) && (age[i] == TO);
        if (cmp) begin
          m_out[i] = 0;
          if (!m_we[i]) begin
            q = sd_q[i*16 +: 16];
            m_dout[i] = m_lsb[i] ? q[15:8] : q[7:0];
          end
        end
        if (tmo) begin
          m_err[i] = 1; m_req[i] = sd_ack[i]; m_out[i] = 0;
        end
        launched = 0;
        if (!m_out[i] && !tmo && (m_hp[i] || st)) begin
          if (m_hp[i]) begin
            la = pa[i]; lw = pw[i]; ld = pd[i]; m_hp[i] = 0;
          end else begin
            la = na; lw = we[i]; ld = din[i*8 +: 8]; st = 0;
          end
          m_req[i] = !m_req[i]; m_out[i] = 1;
          m_a[i] = la[15:1]; m_lsb[i] = la[0]; m_we[i] = lw;
          m_ds[i] = lw ? (la[0] ? 2'b10 : 2'b01) : 2'b11;
          m_d[i] = {ld, ld};
          age[i] = 0; launched = 1;
        end
        if (st) begin
          pa[i] = na; pw[i] = we[i]; pd[i] = din[i*8 +: 8]; m_hp[i] = 1;
        end
        if (!launched && m_out[i] && age[i] < TO) age[i]++;
      end
      p_rd[i] = nrd; p_wr[i] = nwr; p_ad[i] = na;
    end
  end

  // Per-cycle compare against the model, plus toggle bookkeeping.
  int   tog[NP];
  logic [NP-1:0] prev_req = '0;
  bit   seen01 = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("ch%0d busy", i),   busy[i], m_out[i] | m_hp[i]);
        chk($sformatf("ch%0d err", i),    err[i], m_err[i]);
        chk($sformatf("ch%0d dout", i),   dout[i*8 +: 8], m_dout[i]);
        chk($sformatf("ch%0d sd_req", i), sd_req[i], m_req[i]);
        chk($sformatf("ch%0d sd_a", i),   sd_a[i*15 +: 15], m_a[i]);
        chk($sformatf("ch%0d sd_ds", i),  sd_ds[i*2 +: 2], m_ds[i]);
        chk($sformatf("ch%0d sd_we", i),  sd_we[i], m_we[i]);
        chk($sformatf("ch%0d sd_d", i),   sd_d[i*16 +: 16], m_d[i]);
        if (sd_req[i] !== prev_req[i]) begin
          tog[i]++;
          if (i == 0 && sd_a[14:0] == 15'h0001) seen01 = 1;
        end
      end
      prev_req = sd_req;
    end
  end

  task automatic drive(input int ch, input bit c, input bit o, input bit w,
                       input logic [15:0] a, input logic [7:0] d);
    cs[ch] = c; oe[ch] = o; we[ch] = w;
    addr[ch*AW +: AW] = a;
    din[ch*8 +: 8] = d;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int tb;

  initial begin
    for (int i = 0; i < NP; i++) begin
      ack_dly[i] = 0; qval[i] = '0; rage[i] = 0; tog[i] = 0;
    end
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    prev_req = sd_req;
    chk("reset sd_req", sd_req, 2'b00);
    chk("reset busy",   busy,   2'b00);
    chk("reset err",    err,    2'b00);
    chk("reset dout",   dout,   16'h0000);
    step(1);
    reset = 0;
    step(2);

    // Single read on ch0
    ack_dly[0] = 5; qval[0] = 16'hAB12;
    drive(0, 1, 1, 0, 16'h1235, 8'h00);
    @(negedge clk);
    chk("read req before edge", sd_req[0], 1'b0);
    @(posedge clk); @(negedge clk);
    chk("read req toggled", sd_req[0], 1'b1);
    chk("read sd_a", sd_a[14:0], 15'h091A);
    chk("read sd_ds", sd_ds[1:0], 2'b11);
    chk("read sd_we", sd_we[0], 1'b0);
    step(10);
    @(negedge clk);
    chk("read dout", dout[7:0], 8'hAB);
    chk("read busy", busy[0], 1'b0);
    drive(0, 0, 0, 0, 16'h1235, 8'h00);
    step(2);

    // Single write on ch1
    ack_dly[1] = 3;
    tb = tog[1];
    drive(1, 1, 0, 1, 16'h0040, 8'h5A);
    step(1);
    drive(1, 0, 0, 0, 16'h0040, 8'h5A);
    @(negedge clk);
    chk("write sd_ds", sd_ds[3:2], 2'b01);
    chk("write sd_d", sd_d[31:16], 16'h5A5A);
    chk("write sd_we", sd_we[1], 1'b1);
    step(8);
    chk("write toggles", tog[1] - tb, 1);
    chk("write busy", busy[1], 1'b0);

    // Pending slot, newest wins
    ack_dly[0] = 12; qval[0] = 16'h7788;
    tb = tog[0]; seen01 = 0;
    drive(0, 1, 1, 0, 16'h0100, 8'h00);
    step(3);
    drive(0, 1, 1, 0, 16'h0002, 8'h00);
    step(3);
    drive(0, 1, 1, 0, 16'h0004, 8'h00);
    step(35);
    chk("pend toggles", tog[0] - tb, 2);
    chk("pend last sd_a", sd_a[14:0], 15'h0002);
    chk("pend 0002 never issued", seen01, 1'b0);
    chk("pend dout", dout[7:0], 8'h88);
    chk("pend busy", busy[0], 1'b0);
    drive(0, 0, 0, 0, 16'h0004, 8'h00);
    step(2);

    // Address stepping with oe held
    ack_dly[0] = 2; qval[0] = 16'hC3D4;
    tb = tog[0];
    drive(0, 1, 1, 0, 16'h0000, 8'h00);
    step(8);
    chk("astep dout lo", dout[7:0], 8'hD4);
    drive(0, 1, 1, 0, 16'h0001, 8'h00);
    step(8);
    chk("astep dout hi", dout[7:0], 8'hC3);
    drive(0, 1, 1, 0, 16'h0002, 8'h00);
    step(8);
    chk("astep dout lo2", dout[7:0], 8'hD4);
    chk("astep toggles", tog[0] - tb, 3);
    drive(0, 0, 0, 0, 16'h0002, 8'h00);
    step(2);

    // Watchdog: no ack ever
    ack_dly[0] = 0;
    drive(0, 1, 1, 0, 16'h0010, 8'h00);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("wdog err before", err[0], 1'b0);
    chk("wdog busy before", busy[0], 1'b1);
    @(posedge clk); @(negedge clk);
    chk("wdog err", err[0], 1'b1);
    chk("wdog busy", busy[0], 1'b0);
    chk("wdog resync", sd_req[0], sd_ack[0]);
    drive(0, 0, 0, 0, 16'h0010, 8'h00);
    step(5);
    chk("wdog err sticky", err[0], 1'b1);

    // Reset while ch1 has a pending request and no ack
    ack_dly[1] = 0;
    drive(1, 1, 1, 0, 16'h0200, 8'h00);
    step(3);
    drive(1, 1, 1, 0, 16'h0202, 8'h00);
    step(3);
    @(negedge clk);
    chk("rst busy before", busy[1], 1'b1);
    reset = 1;
    @(posedge clk); @(negedge clk);
    chk("rst resync", sd_req[1], sd_ack[1]);
    chk("rst busy", busy[1], 1'b0);
    chk("rst err0 cleared", err[0], 1'b0);
    step(1);
    reset = 0;
    tb = tog[1];
    step(10);
    chk("rst no reissue", tog[1] - tb, 0);
    chk("rst busy after", busy[1], 1'b0);
    drive(1, 0, 0, 0, 16'h0202, 8'h00);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_req_bridge.md
Name: sdram_req_bridge

Overview:
Converts level-style CPU/peripheral memory strobes (cs/oe/we plus a byte address) from NPORTS clients into the toggle req/ack handshake used by the sdram controller's ports. Each channel works independently and maps onto one sdram port; channel 0 serves the CPU and channel 1 serves the FDC or DMA client.
It generalises single-port request generation with these additions:
- one-deep pending request per channel,
- read-data byte extraction,
- busy indication,
- a watchdog that resynchronises a lost handshake.

Parameters:
NPORTS, 2, number of independent client channels (1..4)
AW, 16, client byte-address width
TIMEOUT, 1023, clk cycles a request may remain outstanding before the watchdog fires; 0 disables the watchdog

Ports:
clk  in  1  system clock (same clock as the sdram controller)
reset  in  1  synchronous, active-high
cs  in  NPORTS  per-channel chip select
oe  in  NPORTS  per-channel read enable
we  in  NPORTS  per-channel write enable
addr  in  NPORTS*AW  per-channel byte address; channel i occupies bits [i*AW +: AW]
din  in  NPORTS*8  per-channel write byte
dout  out  NPORTS*8  per-channel read byte, held until the next read completes
busy  out  NPORTS  request outstanding or pending
err  out  NPORTS  sticky flag, set when the watchdog fires; cleared only by reset
sd_req  out  NPORTS  toggle request to sdram port i
sd_ack  in  NPORTS  toggle acknowledge from sdram port i
sd_a  out  NPORTS*(AW-1)  word address = latched addr[AW-1:1]
sd_ds  out  NPORTS*2  byte strobes
sd_we  out  NPORTS  write flag for the request
sd_d  out  NPORTS*16  write data = {byte,byte}
sd_q  in  NPORTS*16  read word from the sdram

Behaviour:
- Reset:
  - sd_req[i] <= sd_ack[i], so the channel is idle-aligned with the controller.
  - pending, err, busy <= 0; dout <= 0; sd_a, sd_ds, sd_we, sd_d <= 0.
  - The edge-detect history registers load the current cs&oe and cs&we, so asserting reset mid-access never yields a spurious trigger.
  - A request outstanding at reset is abandoned and its read data is discarded.
- Trigger (per channel, registered history `rd_old`, `wr_old`, `a_old`), raised on any of:
  - a rising edge of cs&oe;
  - a rising edge of cs&we;
  - cs&oe held high while addr != a_old.
- Capture on trigger: latch op = (we ? write : read), addr, and din.
  - ds = write ? (addr[0] ? 2'b10 : 2'b01) : 2'b11.
  - d = {din,din}.
- Channel FSM, states IDLE, WAIT, WAIT_PEND:
  - IDLE + trigger: drive the sd_* outputs from the capture, toggle sd_req in the same edge, go to WAIT. Latency from strobe edge to sd_req toggle is 1 clk.
  - WAIT + trigger: store the capture in the pending slot, go to WAIT_PEND.
  - WAIT_PEND + trigger: overwrite the pending slot (newest wins). This is not an error.
  - WAIT + sd_ack == sd_req: the request completes. For a read, dout <= addr[0] ? sd_q[15:8] : sd_q[7:0], using the latched addr. Go to IDLE.
  - WAIT_PEND + completion: complete as in WAIT, then issue the pending request in the same cycle and go to WAIT.
  - Completion and a new trigger in the same cycle: the trigger is issued immediately. No cycle is lost and no request is dropped.
- busy: busy = (state != IDLE), combinational from the state register.
- Watchdog:
  - A per-channel counter runs while state != IDLE and clears on completion or reset.
  - When the count reaches TIMEOUT, err is set and sd_req <= sd_ack (forced resync). The pending request, if any, is then issued on the next cycle; otherwise the channel returns to IDLE.
  - The counter saturates and never wraps.
- Sampling: sd_ack and sd_q are synchronous to clk, so no synchroniser is required. sd_q is sampled in the cycle in which the ack match is seen.
- Channels share no state. Arbitration between channels is the sdram controller's job.

Decomposition:
- Package sdram_bridge_pkg:
  - chan_state_t enum (IDLE, WAIT, WAIT_PEND);
  - localparam DS_LO = 2'b01, DS_HI = 2'b10, DS_WORD = 2'b11;
  - function byte_sel(addr0, q16).
- Sub-module sdram_req_chan: one channel containing the FSM, capture/pending registers and watchdog. The top module instantiates it NPORTS times in a generate loop and only slices the packed buses.

Test Plan:
- Read, single: reset; ch0 addr=16'h1235, raise cs&oe.
  -> sd_req0 toggles after 1 clk with sd_a=15'h091A, sd_ds=2'b11, sd_we=0.
  -> Model acks after 5 clks with sd_q=16'hAB12; dout0=8'hAB and busy0=0 on the next clk.
- Write, single: ch1 addr=16'h0040, din=8'h5A, pulse cs&we.
  -> sd_ds1=2'b01, sd_d1=16'h5A5A, sd_we1=1; exactly one toggle on sd_req1.
- Pending: while ch0 is WAIT, present reads to 16'h0002 then 16'h0004 before the ack.
  -> After the ack, exactly one further toggle with sd_a=15'h0002 (latest wins); 16'h0002 is never issued.
- Address change: hold cs&oe, step addr 0→1→2 each 8 clks with prompt acks.
  -> Three requests issued; dout follows q low/high/low bytes.
- Watchdog: TIMEOUT=15; ch0 read, the model never acks.
  -> At clk 16 after issue, err0=1, sd_req0==sd_ack0, busy0=0; err0 stays 1 until reset.
- Reset mid-operation: assert reset while ch1 is WAIT_PEND with the model ack withheld.
  -> sd_req1==sd_ack1 and busy1=0 the cycle after reset; no request is issued after reset deasserts with strobes still held high.
